// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
//   fetch_entry_t : one prefetch queue entry, the fetched word tagged with its PC.
//   is_aligned()  : true when an address is on a 4-byte instruction boundary.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding prefetched instructions for decode.
//   clk, rst_n : clock, async active-low reset (clears every entry and pointer)
//   push_i     : enqueue entry_i; accepted when not full, or when full with pop_i
//   pop_i      : dequeue the head; ignored when empty
//   flush_i    : drop all entries; overrides push_i and pop_i
//   entry_i    : entry to enqueue
//   head_o     : entry at the head, read straight from the storage flops
//   count_o    : number of valid entries
//   empty_o    : no valid entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     entry_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full queue may still accept a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        do_push  = push_i && !flush_i &&
                   ((count_q < CNT_W'(DEPTH)) || (pop_i && (count_q != '0)));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            if (do_pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, addresses a combinational-read instruction memory
// and buffers fetched words for decode behind a valid/ready handshake.
//   clk, rst_n     : clock, async active-low reset
//   run            : fetching permitted; when low the PC holds but the queue drains
//   imem_addr      : byte address to instruction memory (the current PC)
//   imem_rdata     : instruction word for imem_addr, same cycle
//   redirect_valid : load redirect_pc and flush the queue (highest priority)
//   redirect_pc    : new PC; a misaligned target sets fetch_fault
//   out_valid      : queue head holds an instruction
//   out_ready      : decode takes the head this cycle
//   out_instr      : instruction at queue head
//   out_pc         : PC of out_instr
//   fetch_fault    : sticky misaligned-target flag, cleared by an aligned redirect
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic             fault_q, fault_d;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    fetch_entry_t     q_head;
    fetch_entry_t     q_entry;

    // Redirect wins over fetching; a faulted unit stops fetching until re-aimed.
    always_comb begin
        pop     = out_valid && out_ready;
        push    = run && !fault_q && !redirect_valid &&
                  ((q_count < CNT_W'(QUEUE_DEPTH)) || pop);
        pc_d    = pc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            fault_d = !is_aligned(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign q_entry = '{pc: pc_q, instr: imem_rdata};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .entry_i (q_entry),
        .head_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    assign imem_addr   = pc_q;
    assign out_valid   = !q_empty;
    assign out_instr   = q_head.instr;
    assign out_pc      = q_head.pc;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'(a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    instruction_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {pc, instr} plus the fetch PC and fault flag.
    fetch_entry_t mq[$];
    logic [31:0]  mpc    = RESET_PC;
    logic         mfault = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int  n;
        bit  take;
        fetch_entry_t e;
        if (!rst_n) begin
            mq.delete();
            mpc    = RESET_PC;
            mfault = 1'b0;
        end else begin
            n    = mq.size();
            take = (n > 0) && out_ready;
            if (redirect_valid) begin
                mq.delete();
                mpc    = redirect_pc;
                mfault = (redirect_pc[1:0] != 2'b00);
            end else begin
                if (take) e = mq.pop_front();
                if (run && !mfault && (n < DEPTH || take)) begin
                    e.pc    = mpc;
                    e.instr = mem_word(mpc);
                    mq.push_back(e);
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("model_pc", out_pc, mq[0].pc);
            chk("model_instr", out_instr, mq[0].instr);
        end
        chk("model_addr", imem_addr, mpc);
        chk("model_fault", 32'(fetch_fault), 32'(mfault));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        run            = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) cyc();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Stream from reset
        rst_n     = 1'b1;
        run       = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("s1_first_valid", 32'(out_valid), 32'd1);
        chk("s1_pc0", out_pc, 32'h0);
        chk("s1_instr0", out_instr, mem_word(32'h0));
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("s1_pc", out_pc, 32'(4 * i));
            chk("s1_instr", out_instr, mem_word(32'(4 * i)));
        end

        // Backpressure
        out_ready = 1'b0;
        do_redirect(32'h0);
        chk("s2_flush_valid", 32'(out_valid), 32'd0);
        repeat (5) cyc();
        chk("s2_full_valid", 32'(out_valid), 32'd1);
        chk("s2_hold_pc", out_pc, 32'h0);
        chk("s2_hold_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        cyc();
        chk("s2_pc4", out_pc, 32'h4);
        cyc();
        chk("s2_pc8", out_pc, 32'h8);

        // Redirect while full
        out_ready = 1'b0;
        cyc();
        out_ready = 1'b1;
        do_redirect(32'h40);
        chk("s3_valid_after", 32'(out_valid), 32'd0);
        cyc();
        chk("s3_pc40", out_pc, 32'h40);
        cyc();
        chk("s3_pc44", out_pc, 32'h44);

        // Misaligned redirect, then recovery
        do_redirect(32'h42);
        chk("s4_fault", 32'(fetch_fault), 32'd1);
        chk("s4_addr", imem_addr, 32'h42);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s4_no_valid", 32'(out_valid), 32'd0);
        end
        do_redirect(32'h10);
        chk("s4_fault_clr", 32'(fetch_fault), 32'd0);
        cyc();
        chk("s4_pc10", out_pc, 32'h10);

        // PC wrap
        do_redirect(32'hFFFF_FFF8);
        cyc();
        chk("s5_pc_fff8", out_pc, 32'hFFFF_FFF8);
        cyc();
        chk("s5_pc_fffc", out_pc, 32'hFFFF_FFFC);
        cyc();
        chk("s5_pc_0", out_pc, 32'h0000_0000);

        // Async reset between edges with a fault pending
        do_redirect(32'h42);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_valid", 32'(out_valid), 32'd0);
        chk("s6_fault", 32'(fetch_fault), 32'd0);
        chk("s6_addr", imem_addr, RESET_PC);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("s6_restart_pc", out_pc, RESET_PC);
        cyc();
        chk("s6_next_pc", out_pc, RESET_PC + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            run            = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       redirect_pc = 32'($urandom_range(0, 255));
                1:       redirect_pc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                default: redirect_pc = 32'($urandom_range(0, 63)) << 2;
            endcase
            if (i == 1500) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_valid", 32'(out_valid), 32'd0);
                cyc();
                rst_n = 1'b1;
            end
        end

        redirect_valid = 1'b0;
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
